// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// Register-access sequencer that sits in front of a byte-wide SPI master.
// Each request becomes a 2-byte frame pushed into the master->slave FIFO:
//   byte 0 = {R/~W, addr[6:0]}  (bit 7 set for reads)
//   byte 1 = write data, or DUMMY_BYTE for reads
// The two bytes that come back through the slave->master FIFO (show-ahead)
// are consumed. The first byte is discarded. The second byte is the read data
// for reads and is ignored for writes. A single resp_valid pulse reports the
// result, or reports a timeout error if the bytes do not arrive in time.
//
// Ports:
//   clk, n_rst              clock, synchronous active-low reset
//   req_valid/req_ready     request handshake; req_ready is combinational
//   req_rw/req_addr/req_wdata  request payload (1 = read)
//   spi_ready, tx_empty     SPI master idle / master->slave FIFO empty
//   tx_data/tx_wrreq        master->slave FIFO write port (registered)
//   rx_empty/rx_data        slave->master FIFO status and show-ahead head
//   rx_rdreq                slave->master FIFO pop (combinational)
//   resp_valid/resp_rdata/resp_err  one-cycle response, data/err held
//   busy                    transaction in progress
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  DUMMY_BYTE     = 8'h00
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       spi_ready,
    input  logic       tx_empty,
    output logic [7:0] tx_data,
    output logic       tx_wrreq,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_rdreq,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        PUSH_DATA,
        WAIT_RX0,
        WAIT_RX1
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [7:0]  tx_data_q;
    logic        tx_wrreq_q;
    logic        resp_valid_q;
    logic [7:0]  resp_rdata_q;
    logic        resp_err_q;
    logic [15:0] tmo_cnt_q;
    logic        pop_gap_q;

    logic accept;
    logic pop;
    logic tmo_hit;

    always_comb begin
        req_ready = n_rst && (state_q == IDLE) && spi_ready && tx_empty && rx_empty;
        accept    = req_valid && req_ready;
        // Popping is allowed in every state except PUSH_DATA. In IDLE this
        // drains stale bytes left by an aborted transaction. pop_gap_q spaces
        // pops one cycle apart so the FIFO empty flag can catch up.
        pop       = n_rst && (state_q != PUSH_DATA) && !rx_empty && !pop_gap_q;
        tmo_hit   = (tmo_cnt_q == TMO_LAST);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            tx_data_q    <= '0;
            tx_wrreq_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            tmo_cnt_q    <= '0;
            pop_gap_q    <= 1'b0;
        end else begin
            tx_wrreq_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            pop_gap_q    <= pop;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rw_q       <= req_rw;
                        wdata_q    <= req_wdata;
                        tx_data_q  <= {req_rw, req_addr};
                        tx_wrreq_q <= 1'b1;
                        state_q    <= PUSH_DATA;
                    end
                end
                PUSH_DATA: begin
                    tx_data_q  <= rw_q ? DUMMY_BYTE : wdata_q;
                    tx_wrreq_q <= 1'b1;
                    tmo_cnt_q  <= '0;
                    state_q    <= WAIT_RX0;
                end
                WAIT_RX0: begin
                    // A pop on the timeout cycle takes priority over the error.
                    if (pop) begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                        state_q   <= WAIT_RX1;
                    end else if (tmo_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        state_q      <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                WAIT_RX1: begin
                    if (pop) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= rw_q ? rx_data : 8'h00;
                        state_q      <= IDLE;
                    end else if (tmo_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        state_q      <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_wrreq   = tx_wrreq_q;
    assign rx_rdreq   = pop;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       spi_ready = 1'b1;
    logic       tx_empty = 1'b1;
    logic [7:0] tx_data;
    logic       tx_wrreq;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdreq;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic       busy;

    always #5 clk = ~clk;

    spi_reg_ctrl #(
        .TIMEOUT_CYCLES(16),
        .DUMMY_BYTE    (8'h00)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .spi_ready (spi_ready),
        .tx_empty  (tx_empty),
        .tx_data   (tx_data),
        .tx_wrreq  (tx_wrreq),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .rx_rdreq  (rx_rdreq),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       busy;
        int         cyc;
    } resp_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    // FIFO / slave model state (written only by the posedge block)
    logic [7:0] rxq[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         pop_cyc[$];
    int         inj_idx = 0;
    int         underflow_cnt = 0;
    int         cyc = 0;
    // Bytes the bench wants the slave side to return (written by stimulus only)
    logic [7:0] rx_inj[$];
    // Observed responses (written by the monitor only)
    resp_t      resp_obs[$];
    // Scoreboard and counters (written by the stimulus block only)
    exp_t       exp_q[$];
    int         tx_rd = 0;
    int         resp_rd = 0;
    int         pass_cnt = 0;
    int         chk_cnt = 0;

    always @(posedge clk) begin
        if (rx_rdreq) begin
            if (rxq.size() == 0) underflow_cnt <= underflow_cnt + 1;
            else void'(rxq.pop_front());
            pop_cyc.push_back(cyc);
        end
        for (int i = inj_idx; i < rx_inj.size(); i++) rxq.push_back(rx_inj[i]);
        inj_idx <= rx_inj.size();
        if (tx_wrreq) begin
            tx_log.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
        rx_empty <= (rxq.size() == 0);
        rx_data  <= (rxq.size() != 0) ? rxq[0] : 8'h00;
        cyc      <= cyc + 1;
    end

    always @(negedge clk) begin
        if (resp_valid === 1'b1)
            resp_obs.push_back('{rdata: resp_rdata, err: resp_err, busy: busy, cyc: cyc});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] tx_at(input int i);
        return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
    endfunction

    function automatic int txc_at(input int i);
        return (i < tx_cyc.size()) ? tx_cyc[i] : -1;
    endfunction

    function automatic resp_t resp_at(input int i);
        resp_t r;
        r = '{rdata: 8'hxx, err: 1'bx, busy: 1'bx, cyc: -1};
        if (i < resp_obs.size()) r = resp_obs[i];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic drive_req(input logic rw, input logic [6:0] a, input logic [7:0] d,
                             input int budget, output int acc);
        req_rw = rw; req_addr = a; req_wdata = d; req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (req_ready === 1'b1) begin
                acc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_log.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_resp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (resp_obs.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0; req_valid = 1'b0; spi_ready = 1'b1; tx_empty = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (tx_wrreq !== 1'b0) $display("FAIL rst_tx_wrreq: got %b want 0", tx_wrreq); else pass_cnt++;
        chk_cnt++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", tx_data); else pass_cnt++;
        chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else pass_cnt++;
        chk_cnt++; if ({resp_rdata, resp_err} !== 9'h0) $display("FAIL rst_resp: got %h/%b want 00/0", resp_rdata, resp_err); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else pass_cnt++;
        chk_cnt++; if (rx_rdreq !== 1'b0) $display("FAIL rst_rx_rdreq: got %b want 0", rx_rdreq); else pass_cnt++;
        n_rst = 1'b1; #1;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_write;
        int acc; bit ok; exp_t e; resp_t r;
        exp_q.push_back('{rdata: 8'h00, err: 1'b0});
        drive_req(1'b0, 7'h15, 8'hA5, 20, acc);
        chk_cnt++; if (acc < 0) $display("FAIL wr_accept: got none want accept"); else pass_cnt++;
        wait_tx(tx_rd + 2, ok);
        chk_cnt++; if (tx_at(tx_rd) !== 8'h15) $display("FAIL wr_tx0: got %h want 15", tx_at(tx_rd)); else pass_cnt++;
        chk_cnt++; if (tx_at(tx_rd + 1) !== 8'hA5) $display("FAIL wr_tx1: got %h want a5", tx_at(tx_rd + 1)); else pass_cnt++;
        chk_cnt++; if (txc_at(tx_rd) !== acc + 1 || txc_at(tx_rd + 1) !== acc + 2)
            $display("FAIL wr_tx_cycles: got %0d,%0d want %0d,%0d", txc_at(tx_rd), txc_at(tx_rd + 1), acc + 1, acc + 2);
        else pass_cnt++;
        tx_rd += 2;
        rx_inj.push_back(8'h15); rx_inj.push_back(8'hA5);
        wait_resp(resp_rd + 1, 50, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL wr_resp_seen: got none want response"); else pass_cnt++;
        e = exp_q.pop_front(); r = resp_at(resp_rd); resp_rd++;
        chk_cnt++; if ({r.rdata, r.err} !== {e.rdata, e.err})
            $display("FAIL wr_resp: got %h/%b want %h/%b", r.rdata, r.err, e.rdata, e.err);
        else pass_cnt++;
        chk_cnt++; if (r.busy !== 1'b0) $display("FAIL wr_resp_busy: got %b want 0", r.busy); else pass_cnt++;
        chk_cnt++; if (tx_log.size() !== tx_rd) $display("FAIL wr_tx_count: got %0d want %0d", tx_log.size(), tx_rd); else pass_cnt++;
    endtask

    task automatic test_timeout;
        int acc; bit ok; exp_t e; resp_t r; int p0; int viol;
        exp_q.push_back('{rdata: 8'h00, err: 1'b1});
        drive_req(1'b1, 7'h0A, 8'h00, 20, acc);
        wait_tx(tx_rd + 2, ok);
        chk_cnt++; if (tx_at(tx_rd) !== 8'h8A) $display("FAIL to_tx0: got %h want 8a", tx_at(tx_rd)); else pass_cnt++;
        tx_rd += 2;
        wait_resp(resp_rd + 1, 40, ok);
        e = exp_q.pop_front(); r = resp_at(resp_rd); resp_rd++;
        chk_cnt++; if ({r.rdata, r.err} !== {e.rdata, e.err})
            $display("FAIL to_resp: got %h/%b want %h/%b", r.rdata, r.err, e.rdata, e.err);
        else pass_cnt++;
        // WAIT_RX0 is entered after edge acc+1; error pulse visible 16 cycles later
        chk_cnt++; if (r.cyc !== acc + 18) $display("FAIL to_latency: got cycle %0d want %0d", r.cyc, acc + 18); else pass_cnt++;
        p0 = pop_cyc.size(); viol = 0;
        rx_inj.push_back(8'h11); rx_inj.push_back(8'h22);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (!rx_empty && req_ready) viol++;
        end
        chk_cnt++; if (viol !== 0) $display("FAIL to_ready_while_rx: got %0d cycles want 0", viol); else pass_cnt++;
        chk_cnt++; if (pop_cyc.size() - p0 !== 2) $display("FAIL to_drain_pops: got %0d want 2", pop_cyc.size() - p0); else pass_cnt++;
        chk_cnt++; if ({rx_empty, req_ready} !== 2'b11) $display("FAIL to_drained: got %b want 11", {rx_empty, req_ready}); else pass_cnt++;
    endtask

    task automatic test_stall;
        int acc; bit ok; exp_t e; resp_t r; int viol;
        viol = 0;
        req_rw = 1'b0; req_addr = 7'h22; req_wdata = 8'h3C;
        spi_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; if (req_ready || tx_wrreq || busy) viol++;
            @(negedge clk);
        end
        spi_ready = 1'b1; tx_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; if (req_ready || tx_wrreq || busy) viol++;
            @(negedge clk);
        end
        chk_cnt++; if (viol !== 0) $display("FAIL stall_no_accept: got %0d cycles want 0", viol); else pass_cnt++;
        chk_cnt++; if (tx_log.size() !== tx_rd) $display("FAIL stall_no_tx: got %0d want %0d", tx_log.size(), tx_rd); else pass_cnt++;
        tx_empty = 1'b1; #1;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL stall_ready: got %b want 1", req_ready); else pass_cnt++;
        acc = cyc;
        exp_q.push_back('{rdata: 8'h00, err: 1'b0});
        @(negedge clk); req_valid = 1'b0;
        wait_tx(tx_rd + 2, ok);
        chk_cnt++; if (txc_at(tx_rd) !== acc + 1) $display("FAIL stall_accept_cycle: got %0d want %0d", txc_at(tx_rd), acc + 1); else pass_cnt++;
        chk_cnt++; if ({tx_at(tx_rd), tx_at(tx_rd + 1)} !== 16'h223C)
            $display("FAIL stall_tx: got %h%h want 223c", tx_at(tx_rd), tx_at(tx_rd + 1));
        else pass_cnt++;
        tx_rd += 2;
        rx_inj.push_back(8'h22); rx_inj.push_back(8'h3C);
        wait_resp(resp_rd + 1, 50, ok);
        e = exp_q.pop_front(); r = resp_at(resp_rd); resp_rd++;
        chk_cnt++; if ({r.rdata, r.err} !== {e.rdata, e.err})
            $display("FAIL stall_resp: got %h/%b want %h/%b", r.rdata, r.err, e.rdata, e.err);
        else pass_cnt++;
    endtask

    task automatic test_read;
        int acc; bit ok; exp_t e; resp_t r; int p0;
        exp_q.push_back('{rdata: 8'h5C, err: 1'b0});
        p0 = pop_cyc.size();
        drive_req(1'b1, 7'h03, 8'hEE, 20, acc);
        wait_tx(tx_rd + 2, ok);
        chk_cnt++; if ({tx_at(tx_rd), tx_at(tx_rd + 1)} !== 16'h8300)
            $display("FAIL rd_tx: got %h%h want 8300", tx_at(tx_rd), tx_at(tx_rd + 1));
        else pass_cnt++;
        tx_rd += 2;
        rx_inj.push_back(8'hFF); rx_inj.push_back(8'h5C);
        wait_resp(resp_rd + 1, 50, ok);
        e = exp_q.pop_front(); r = resp_at(resp_rd); resp_rd++;
        chk_cnt++; if ({r.rdata, r.err} !== {e.rdata, e.err})
            $display("FAIL rd_resp: got %h/%b want %h/%b", r.rdata, r.err, e.rdata, e.err);
        else pass_cnt++;
        chk_cnt++; if (pop_cyc.size() - p0 !== 2) $display("FAIL rd_pops: got %0d want 2", pop_cyc.size() - p0); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int acc; bit ok; exp_t e; resp_t r; int p0; int r0;
        drive_req(1'b1, 7'h05, 8'h00, 20, acc);
        wait_tx(tx_rd + 2, ok);
        tx_rd += 2;
        p0 = pop_cyc.size();
        rx_inj.push_back(8'hAB);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pop_cyc.size() > p0) break;
        end
        chk_cnt++; if (busy !== 1'b1) $display("FAIL rm_in_wait_rx1: got busy %b want 1", busy); else pass_cnt++;
        r0 = resp_obs.size();
        n_rst = 1'b0;
        rx_inj.push_back(8'hCD);
        @(negedge clk); #1;
        chk_cnt++; if ({busy, tx_wrreq, tx_data, resp_valid, resp_rdata, resp_err} !== 20'h0)
            $display("FAIL rm_outputs: got busy=%b wr=%b txd=%h rv=%b rd=%h err=%b want all 0",
                     busy, tx_wrreq, tx_data, resp_valid, resp_rdata, resp_err);
        else pass_cnt++;
        chk_cnt++; if ({rx_empty, rx_rdreq, req_ready} !== 3'b000)
            $display("FAIL rm_no_pop_in_reset: got empty/rdreq/ready=%b want 000", {rx_empty, rx_rdreq, req_ready});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        p0 = pop_cyc.size();
        exp_q.push_back('{rdata: 8'h00, err: 1'b0});
        drive_req(1'b0, 7'h10, 8'h99, 20, acc);
        chk_cnt++; if (resp_obs.size() !== r0) $display("FAIL rm_no_resp: got %0d responses want %0d", resp_obs.size(), r0); else pass_cnt++;
        chk_cnt++; if (pop_cyc.size() - p0 !== 1 || acc < 0 || pop_cyc[p0] >= acc)
            $display("FAIL rm_leftover_pop: got %0d pops, accept %0d want 1 pop before accept", pop_cyc.size() - p0, acc);
        else pass_cnt++;
        wait_tx(tx_rd + 2, ok);
        chk_cnt++; if ({tx_at(tx_rd), tx_at(tx_rd + 1)} !== 16'h1099)
            $display("FAIL rm_tx: got %h%h want 1099", tx_at(tx_rd), tx_at(tx_rd + 1));
        else pass_cnt++;
        tx_rd += 2;
        rx_inj.push_back(8'h10); rx_inj.push_back(8'h99);
        wait_resp(resp_rd + 1, 50, ok);
        e = exp_q.pop_front(); r = resp_at(resp_rd); resp_rd++;
        chk_cnt++; if ({r.rdata, r.err} !== {e.rdata, e.err})
            $display("FAIL rm_resp: got %h/%b want %h/%b", r.rdata, r.err, e.rdata, e.err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int acc1; int acc2; bit ok; exp_t e; resp_t r;
        exp_q.push_back('{rdata: 8'hC3, err: 1'b0});
        exp_q.push_back('{rdata: 8'h00, err: 1'b0});
        drive_req(1'b1, 7'h01, 8'h00, 20, acc1);
        wait_tx(tx_rd + 2, ok);
        rx_inj.push_back(8'hFF); rx_inj.push_back(8'hC3);
        drive_req(1'b0, 7'h02, 8'h7E, 40, acc2);
        wait_tx(tx_rd + 4, ok);
        rx_inj.push_back(8'h02); rx_inj.push_back(8'h7E);
        wait_resp(resp_rd + 2, 60, ok);
        chk_cnt++; if ({tx_at(tx_rd), tx_at(tx_rd + 1), tx_at(tx_rd + 2), tx_at(tx_rd + 3)} !== 32'h8100027E)
            $display("FAIL b2b_tx: got %h %h %h %h want 81 00 02 7e",
                     tx_at(tx_rd), tx_at(tx_rd + 1), tx_at(tx_rd + 2), tx_at(tx_rd + 3));
        else pass_cnt++;
        chk_cnt++; if (txc_at(tx_rd + 1) !== txc_at(tx_rd) + 1 || txc_at(tx_rd + 3) !== txc_at(tx_rd + 2) + 1
                       || txc_at(tx_rd + 2) <= txc_at(tx_rd + 1) + 1)
            $display("FAIL b2b_tx_cycles: got %0d %0d %0d %0d want paired and separated",
                     txc_at(tx_rd), txc_at(tx_rd + 1), txc_at(tx_rd + 2), txc_at(tx_rd + 3));
        else pass_cnt++;
        tx_rd += 4;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front(); r = resp_at(resp_rd); resp_rd++;
            chk_cnt++; if ({r.rdata, r.err} !== {e.rdata, e.err})
                $display("FAIL b2b_resp%0d: got %h/%b want %h/%b", k, r.rdata, r.err, e.rdata, e.err);
            else pass_cnt++;
        end
    endtask

    task automatic test_pop_spacing;
        int adj;
        adj = 0;
        for (int i = 1; i < pop_cyc.size(); i++)
            if (pop_cyc[i] - pop_cyc[i - 1] < 2) adj++;
        chk_cnt++; if (adj !== 0) $display("FAIL pop_adjacent: got %0d adjacent pops want 0", adj); else pass_cnt++;
        chk_cnt++; if (underflow_cnt !== 0) $display("FAIL pop_underflow: got %0d want 0", underflow_cnt); else pass_cnt++;
        chk_cnt++; if (resp_obs.size() !== resp_rd) $display("FAIL resp_count: got %0d want %0d", resp_obs.size(), resp_rd); else pass_cnt++;
        chk_cnt++; if (tx_log.size() !== tx_rd) $display("FAIL tx_count: got %0d want %0d", tx_log.size(), tx_rd); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_timeout();
        test_stall();
        test_read();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        test_pop_spacing();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
